// File: rtl/branch_pc_unit.sv
// Program counter, next-PC selection, retired-instruction counter and
// run/halt/fault control for the single-cycle RV core.
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic [2:0]  br_type_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] alu_result_i,
  input  logic        sf_i,
  input  logic        zf_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        taken_o,
  output logic        halted_o,
  output logic        fault_o,
  output logic [31:0] retired_o
);

  localparam logic [2:0] BrSeq  = 3'd0;
  localparam logic [2:0] BrBeq  = 3'd1;
  localparam logic [2:0] BrBne  = 3'd2;
  localparam logic [2:0] BrBlt  = 3'd3;
  localparam logic [2:0] BrBge  = 3'd4;
  localparam logic [2:0] BrJal  = 3'd5;
  localparam logic [2:0] BrJalr = 3'd6;
  localparam logic [2:0] BrHalt = 3'd7;

  typedef enum logic [1:0] {StRun, StHalt, StFault} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] retired_q, retired_d;

  logic        taken;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic [31:0] next_pc;
  logic        misaligned;

  // Branch decode; BLT/BGE trust SF alone, so A-B overflow is not corrected.
  always_comb begin
    taken = 1'b0;
    unique case (br_type_i)
      BrSeq:   taken = 1'b0;
      BrBeq:   taken = zf_i;
      BrBne:   taken = ~zf_i;
      BrBlt:   taken = sf_i;
      BrBge:   taken = ~sf_i;
      BrJal:   taken = 1'b1;
      BrJalr:  taken = 1'b1;
      BrHalt:  taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

  // Target and next-PC selection; all adds wrap modulo 2^32.
  always_comb begin
    pc_plus4   = pc_q + 32'd4;
    target     = (br_type_i == BrJalr) ? (alu_result_i & ~32'h1) : (pc_q + imm_i);
    next_pc    = taken ? target : pc_plus4;
    misaligned = taken & target[1];
  end

  // Control FSM and PC/counter next-state; HALT and FAULT are terminal until reset.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    unique case (state_q)
      StRun: begin
        if (en_i) begin
          if (br_type_i == BrHalt) begin
            state_d   = StHalt;
            retired_d = retired_q + 32'd1;
          end else if (misaligned) begin
            state_d = StFault;
          end else begin
            pc_d      = next_pc;
            retired_d = retired_q + 32'd1;
          end
        end
      end
      StHalt:  state_d = StHalt;
      StFault: state_d = StFault;
      default: state_d = StFault;
    endcase
  end

  // State, PC and counter registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StRun;
      pc_q      <= RESET_PC;
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
    end
  end

  // Outputs.
  always_comb begin
    pc_o       = pc_q;
    pc_plus4_o = pc_plus4;
    taken_o    = taken;
    halted_o   = (state_q == StHalt);
    fault_o    = (state_q == StFault);
    retired_o  = retired_q;
  end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Scoreboard bench for branch_pc_unit: the driver updates a behavioural model
// and queues expectations; the monitor checks the DUT against them each cycle.
module tb_branch_pc_unit;

  localparam logic [31:0] RstPc = 32'h0000_0000;
  localparam logic [2:0] SEQ = 3'd0, BEQ = 3'd1, BNE = 3'd2, BLT = 3'd3;
  localparam logic [2:0] BGE = 3'd4, JAL = 3'd5, JALR = 3'd6, HALT = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [2:0]  br_type = 3'd0;
  logic [31:0] imm = '0;
  logic [31:0] alu_result = '0;
  logic        sf = 1'b0;
  logic        zf = 1'b0;
  logic [31:0] pc, pc_plus4, retired;
  logic        taken, halted, fault;

  branch_pc_unit #(.RESET_PC(RstPc)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (en),
    .br_type_i   (br_type),
    .imm_i       (imm),
    .alu_result_i(alu_result),
    .sf_i        (sf),
    .zf_i        (zf),
    .pc_o        (pc),
    .pc_plus4_o  (pc_plus4),
    .taken_o     (taken),
    .halted_o    (halted),
    .fault_o     (fault),
    .retired_o   (retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pre_pc, pre_ret, pre_p4;
    logic        pre_tk, pre_h, pre_f;
    logic [31:0] post_pc, post_ret;
    logic        post_h, post_f;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  // Behavioural model: architectural PC, retired count and terminal flags.
  logic [31:0] m_pc = RstPc;
  logic [31:0] m_ret = '0;
  bit          m_halt = 1'b0;
  bit          m_fault = 1'b0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endfunction

  function automatic bit model_taken(input logic [2:0] br, input bit s, input bit z);
    case (br)
      BEQ:       return z;
      BNE:       return !z;
      BLT:       return s;
      BGE:       return !s;
      JAL, JALR: return 1'b1;
      default:   return 1'b0;
    endcase
  endfunction

  // Drive one cycle of inputs at the falling edge and queue the expected response.
  task automatic cyc(input bit rn, input bit e, input logic [2:0] br, input logic [31:0] im,
                     input logic [31:0] alu, input bit s, input bit z);
    exp_t x;
    bit tk;
    logic [31:0] tgt;
    @(negedge clk);
    rst_n = rn; en = e; br_type = br; imm = im; alu_result = alu; sf = s; zf = z;
    if (!rn) begin
      m_pc = RstPc; m_ret = 0; m_halt = 0; m_fault = 0;
    end
    tk  = model_taken(br, s, z);
    tgt = (br == JALR) ? {alu[31:1], 1'b0} : m_pc + im;
    x.pre_pc = m_pc; x.pre_ret = m_ret; x.pre_h = m_halt; x.pre_f = m_fault;
    x.pre_tk = tk;   x.pre_p4 = m_pc + 32'd4;
    if (rn && e && !m_halt && !m_fault) begin
      if (br == HALT) begin
        m_halt = 1; m_ret = m_ret + 1;
      end else if (tk && tgt[1]) begin
        m_fault = 1;
      end else begin
        m_pc  = tk ? tgt : m_pc + 32'd4;
        m_ret = m_ret + 1;
      end
    end
    x.post_pc = m_pc; x.post_ret = m_ret; x.post_h = m_halt; x.post_f = m_fault;
    q.push_back(x);
  endtask

  task automatic op(input logic [2:0] br, input logic [31:0] im, input logic [31:0] alu,
                    input bit s, input bit z);
    cyc(1'b1, 1'b1, br, im, alu, s, z);
  endtask

  task automatic rst();
    cyc(1'b0, 1'b1, SEQ, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  // Monitor: combinational/current values mid-low-phase, registered values after the edge.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #4;
      if (q.size() > 0) begin
        x = q[0];
        chk("pre_pc", pc, x.pre_pc);
        chk("pre_retired", retired, x.pre_ret);
        chk("pre_halted", 32'(halted), 32'(x.pre_h));
        chk("pre_fault", 32'(fault), 32'(x.pre_f));
        chk("taken", 32'(taken), 32'(x.pre_tk));
        chk("pc_plus4", pc_plus4, x.pre_p4);
        @(posedge clk);
        #1;
        chk("post_pc", pc, x.post_pc);
        chk("post_retired", retired, x.post_ret);
        chk("post_halted", 32'(halted), 32'(x.post_h));
        chk("post_fault", 32'(fault), 32'(x.post_f));
        void'(q.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] a, b, r, im, alu;
    logic [2:0]  br;
    // Reset and sequential flow.
    rst(); rst();
    repeat (3) op(SEQ, 32'h0, 32'h0, 1'b0, 1'b0);
    // Branch decode from pc=0x10.
    rst(); op(JAL, 32'h10, 0, 0, 0); op(BEQ, 32'h20, 0, 0, 1);
    rst(); op(JAL, 32'h10, 0, 0, 0); op(BEQ, 32'h20, 5, 0, 0);
    rst(); op(JAL, 32'h10, 0, 0, 0); op(BLT, 32'hFFFF_FFF8, 32'h8000_0000, 1, 0);
    rst(); op(JAL, 32'h10, 0, 0, 0); op(BGE, 32'hFFFF_FFF8, 32'h8000_0000, 1, 0);
    op(BNE, 32'h8, 0, 0, 1); op(BNE, 32'h8, 3, 0, 0);
    // Jumps and JALR bit0 clearing.
    rst(); op(JAL, 32'h40, 0, 0, 0); op(JAL, 32'h100, 0, 0, 0);
    op(JALR, 32'h0, 32'h201, 0, 0);
    // Misaligned JALR faults; later inputs ignored; reset recovers.
    op(JALR, 32'h0, 32'h202, 0, 0);
    op(SEQ, 0, 0, 0, 0); op(JAL, 32'h8, 0, 0, 0); op(HALT, 0, 0, 0, 0);
    rst(); op(SEQ, 0, 0, 0, 0);
    // Misaligned branch target.
    op(BEQ, 32'h6, 0, 0, 1);
    // Stall, then halt and frozen state.
    rst(); op(SEQ, 0, 0, 0, 0);
    cyc(1'b1, 1'b0, JAL, 32'h100, 0, 0, 0);
    cyc(1'b1, 1'b0, HALT, 32'h0, 0, 0, 0);
    cyc(1'b1, 1'b0, JALR, 32'h0, 32'h2, 0, 0);
    op(HALT, 0, 0, 0, 0);
    repeat (5) op(SEQ, 0, 0, 0, 0);
    // PC wrap.
    rst(); op(JAL, 32'hFFFF_FFFC, 0, 0, 0); op(SEQ, 0, 0, 0, 0); op(SEQ, 0, 0, 0, 0);
    // Randomized stream with occasional reset, stall, halt and misalignment.
    rst();
    for (int i = 0; i < 600; i++) begin
      br = 3'($urandom_range(0, 6));
      if ($urandom_range(0, 40) == 0) br = HALT;
      im = $urandom;
      if ($urandom_range(0, 7) != 0) im[1:0] = 2'b00;
      if (br == JALR) begin
        alu = $urandom;
        if ($urandom_range(0, 7) != 0) alu[1] = 1'b0;
        r = alu;
      end else begin
        a = $urandom;
        b = ($urandom_range(0, 2) == 0) ? a : $urandom;
        r = a - b;
        alu = r;
      end
      cyc(($urandom_range(0, 30) != 0), ($urandom_range(0, 4) != 0), br, im, alu,
          r[31], (r == 32'h0));
      if ((m_halt || m_fault) && $urandom_range(0, 3) == 0) rst();
    end
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/branch_pc_unit.md
# branch_pc_unit

- Holds the program counter of the single-cycle RV core.
- Downstream of the ALU: consumes its result and its SF/ZF flags to decide the next PC.
- Branches drive the ALU with A−B; jumps drive it with base+imm.
- Provides the link value (PC+4), a retired-instruction counter and a small run/halt/fault state machine that freezes the core on halt or misaligned control transfer.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (must be 4-byte aligned)

Ports (reset is asynchronous, active-low; single clock):
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  advance this cycle; 0 = stall (PC, counter, state hold)
- br_type  in  3  0 SEQ, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 JAL, 6 JALR, 7 HALT
- imm  in  32  sign-extended branch/JAL offset, bytes
- alu_result  in  32  ALU result (JALR target = rs1+imm)
- sf  in  1  ALU sign flag (result[31])
- zf  in  1  ALU zero flag (result==0)
- pc  out  32  current PC register
- pc_plus4  out  32  pc+4, combinational (link value for JAL/JALR)
- taken  out  1  combinational: current instruction redirects the PC
- halted  out  1  state==HALT
- fault  out  1  state==FAULT
- retired  out  32  count of instructions retired

## Operation

States: RUN, HALT, FAULT. Reset → RUN.

Taken decode (combinational, every state):
- SEQ 0
- BEQ zf
- BNE !zf
- BLT sf
- BGE !sf
- JAL 1
- JALR 1
- HALT 0

BLT/BGE use SF only. Signed overflow of A−B is not corrected. This is a documented limitation matching the ALU's flag set.

Target:
- BEQ/BNE/BLT/BGE/JAL: pc + imm, mod 2^32.
- JALR: alu_result & ~32'h1.
- next_pc = taken ? target : pc_plus4, mod 2^32 (wraps 0xFFFF_FFFC → 0).

Misalignment: taken && target[1]==1 → misaligned. Not taken never faults.

In RUN with en=1, at the clock edge:
- HALT: state→HALT, pc unchanged, retired+1.
- Misaligned: state→FAULT, pc unchanged, retired unchanged.
- Otherwise: pc←next_pc, retired+1.

In RUN with en=0: nothing changes.

HALT and FAULT:
- Terminal: pc and retired frozen.
- en and br_type are ignored; only rst_n exits.
- taken still reflects decode but has no effect.

retired wraps 0xFFFF_FFFF → 0.

## Timing

- Reset values (asynchronous, take effect immediately when rst_n low):
  - pc=RESET_PC
  - retired=0
  - halted=0
  - fault=0
  - state=RUN
- Reset released mid-stream: first update on the first rising edge with rst_n=1 and en=1.
- Latency:
  - pc, retired, halted and fault are registered and update one edge after the deciding inputs.
  - taken and pc_plus4 are combinational from pc and the current inputs.
- Asserting rst_n low while in HALT/FAULT returns to RUN with reset values; no edge is needed.
- en=0 on the same edge as HALT or a misaligned target: no transition.

## Test plan

- Reset / sequential: rst_n low then high, RESET_PC=0, br_type=SEQ, en=1 for 3 edges → pc 0,4,8,12; retired=3; taken=0.
- Branch decode:
  - pc=0x10, BEQ, imm=0x20, zf=1 → taken=1, next pc=0x30.
  - Same with zf=0 → pc=0x14.
  - BLT sf=1, imm=−8 (0xFFFF_FFF8) → pc=0x08.
  - BGE sf=1 → pc=0x14.
- Jumps:
  - pc=0x40, JAL imm=0x100 → pc=0x140, pc_plus4=0x44 before the edge.
  - JALR alu_result=0x201 → pc=0x200 (bit0 cleared).
- Fault: JALR alu_result=0x202 → fault=1 next edge, pc stays, retired unchanged. Further en/br_type have no effect; rst_n low → pc=RESET_PC, fault=0.
- Halt / stall:
  - en=0 with JAL → pc/retired unchanged.
  - HALT with en=1 → halted=1, retired+1; 5 more edges with SEQ → pc frozen.
- Wrap: pc=0xFFFF_FFFC (via JAL from 0, imm=0xFFFF_FFFC), SEQ → pc=0x0. Preloading retired is not possible, so the counter wrap is checked by a long-run simulation or formal property only.
